y_row_addr_gen: RTL
===================

# y_row_addr_gen

Parametrised Y-matrix row address generator for the change-of-Y integration path. It accepts a row number over a valid/ready handshake and fetches the index line that holds that row's pointer from Y memory. It extracts the pointer field and emits a burst of NUM_LINES consecutive line addresses (pointer, pointer+1, ...) to the Y read stage. It generalises the fixed two-address, 11-bit decoder with configurable widths and burst length, handshakes on both sides, and empty-row signalling.

## Interface
Parameters:
- ROW_W, 16: row number width.
- ADDR_W, 11: Y memory line address width.
- DATA_W, 256: Y memory line width.
- ROWS_LOG2, 4: log2 of pointers per index line. PTR_W = DATA_W >> ROWS_LOG2; ADDR_W <= PTR_W is required.
- NUM_LINES, 2: addresses emitted per row (>= 1).
- INDEX_BASE, 0: line address of the first index line.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  row request valid.
- req_ready  out  1  block idle, can accept a request.
- req_row  in  ROW_W  requested row number.
- mem_rd_en  out  1  one-cycle index-line read strobe.
- mem_rd_addr  out  ADDR_W  index-line address.
- mem_rd_valid  in  1  mem_rd_data valid this cycle.
- mem_rd_data  in  DATA_W  index-line contents.
- out_valid  out  1  out_addr valid.
- out_ready  in  1  consumer accepts the beat.
- out_addr  out  ADDR_W  generated line address.
- out_last  out  1  final beat of the row.
- out_empty  out  1  row has no data (null pointer).

## Operation
- FSM states: IDLE, FETCH, WAIT, EMIT. All outputs are registered.
- **IDLE:** req_ready=1. On req_valid&req_ready, latch req_row and go to FETCH.
- **FETCH** (exactly 1 cycle):
  - mem_rd_en=1.
  - mem_rd_addr = (INDEX_BASE + (row >> ROWS_LOG2)) mod 2^ADDR_W.
  - Go to WAIT.
- **WAIT:** mem_rd_en=0; mem_rd_addr holds its value.
  - On mem_rd_valid: sel = row[ROWS_LOG2-1:0]; ptr = mem_rd_data[sel*PTR_W +: PTR_W][ADDR_W-1:0].
  - Go to EMIT with beat counter = 0.
  - mem_rd_valid is ignored in every other state.
- **EMIT:** out_valid=1.
  - Normal case: out_addr = (ptr + beat) mod 2^ADDR_W; out_last=1 on beat NUM_LINES-1.
  - Null pointer (ptr = all ones): a single beat with out_addr=all ones, out_empty=1, out_last=1.
  - On out_valid&out_ready: advance the beat. After the last beat, go to IDLE.
  - Addresses wrap modulo 2^ADDR_W. All-ones is a sentinel only as a pointer value; it may appear as a non-empty generated address after wrap.
- No request queueing: exactly one row is in flight.
- Reset returns the FSM to IDLE from any state and discards the in-flight row. A late mem_rd_valid after reset produces no output.

## Timing
- Reset values:
  - req_ready=1 (the first cycle after reset deasserts).
  - mem_rd_en=0, mem_rd_addr=all ones.
  - out_valid=0, out_addr=all ones, out_last=0, out_empty=0.
- Request sampled at edge T → mem_rd_en high in cycle T+1.
- mem_rd_valid sampled at edge W → first out_valid in cycle W+1.
- With 1-cycle memory (mem_rd_valid in cycle T+2), out_valid first rises in cycle T+3.
- Each beat holds out_addr, out_last and out_empty stable while out_valid=1 and out_ready=0. The next beat follows the cycle after acceptance.
- After the last beat is accepted, req_ready=1 the next cycle.
- Minimum request period with no backpressure and 1-cycle memory: 3 + NUM_LINES cycles (1 for an empty row: 4 cycles).
- Combinational req_valid→req_ready and out_ready→out_valid paths are forbidden.

## Test plan
- **Reset:** hold reset=0 for 2 cycles during EMIT → next cycle req_ready=1, out_valid=0, out_addr=0x7FF, mem_rd_addr=0x7FF, mem_rd_en=0.
- **Basic fetch** (defaults): req_row=0x0123; mem returns field 3 = 0x0040 one cycle after the strobe.
  - Expect mem_rd_addr=0x012 with mem_rd_en for one cycle.
  - Expect beats 0x040 (last=0) then 0x041 (last=1). req_ready returns after the second acceptance.
- **Empty row:** field = 0xFFFF → single beat out_addr=0x7FF, out_empty=1, out_last=1, then IDLE.
- **Wrap** (NUM_LINES=4, INDEX_BASE=0x700): req_row=0x0012, field 2 = 0x07FE.
  - Expect mem_rd_addr=0x701.
  - Expect beats 0x7FE, 0x7FF, 0x000, 0x001 with out_empty=0 throughout.
- **Backpressure:** out_ready=0 for 3 cycles on beat 0 while req_valid is held high.
  - out_addr is stable and req_ready=0 throughout.
  - The second request is accepted only after beat 1 completes.
- **Reset mid-WAIT:** reset asserted while in WAIT; mem_rd_valid arrives 2 cycles later → no out_valid, req_ready=1, mem_rd_en stays 0.

Source files
------------

// File: rtl/y_row_addr_gen.sv
// Y-matrix row address generator: row number -> index-line fetch -> burst of NUM_LINES line addresses.
// Latency: request edge T -> mem_rd_en in T+1; mem_rd_valid edge W -> first out_valid in W+1.
// Backpressure: one row in flight; req_ready low until the last beat is accepted; beats hold under out_ready=0.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-low reset
//   req_valid/req_ready  row request handshake, req_row = requested row number
//   mem_rd_en/addr       one-cycle index-line read strobe and its address (address held afterwards)
//   mem_rd_valid/data    index-line read return, only looked at while waiting for it
//   out_valid/out_ready  generated address handshake
//   out_addr/last/empty  line address, final beat of the row, row has no data (null pointer)
module y_row_addr_gen #(
  parameter int ROW_W      = 16,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 256,
  parameter int ROWS_LOG2  = 4,
  parameter int NUM_LINES  = 2,
  parameter int INDEX_BASE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ROW_W-1:0]  req_row,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              out_empty
);

  localparam int PTR_W  = DATA_W >> ROWS_LOG2;
  localparam int BEAT_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_LINES - 1);
  localparam logic [ADDR_W-1:0] NULL_PTR  = '1;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, EMIT} stateT;

  stateT                state;
  logic [ROWS_LOG2-1:0] selQ;   // pointer slot within the index line
  logic [BEAT_W-1:0]    beatQ;
  logic [BEAT_W-1:0]    beatNext;
  logic [ADDR_W-1:0]    fetchedPtr;

  // Shift the selected pointer field down to bit 0; the size cast keeps only
  // the low ADDR_W bits, which is the pointer as the Y read stage sees it.
  assign fetchedPtr = ADDR_W'(mem_rd_data >> (int'(selQ) * PTR_W));
  assign beatNext   = beatQ + BEAT_W'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      selQ        <= '0;
      beatQ       <= '0;
      req_ready   <= 1'b1;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '1;
      out_valid   <= 1'b0;
      out_addr    <= '1;
      out_last    <= 1'b0;
      out_empty   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            selQ        <= req_row[ROWS_LOG2-1:0];
            req_ready   <= 1'b0;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= ADDR_W'(INDEX_BASE) + ADDR_W'(req_row >> ROWS_LOG2);
            state       <= FETCH;
          end
        end

        FETCH: begin
          mem_rd_en <= 1'b0;
          state     <= WAIT;
        end

        WAIT: begin
          if (mem_rd_valid) begin
            beatQ     <= '0;
            out_valid <= 1'b1;
            out_addr  <= fetchedPtr;
            // A null pointer collapses the burst to one flagged beat.
            if (fetchedPtr == NULL_PTR) begin
              out_empty <= 1'b1;
              out_last  <= 1'b1;
            end else begin
              out_empty <= 1'b0;
              out_last  <= (LAST_BEAT == '0);
            end
            state <= EMIT;
          end
        end

        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_empty <= 1'b0;
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              // Wraps modulo 2^ADDR_W; all-ones here is an ordinary address.
              beatQ    <= beatNext;
              out_addr <= out_addr + ADDR_W'(1);
              out_last <= (beatNext == LAST_BEAT);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
